stripe_packer: RTL and testbench
================================

// Module: stripe_packer
// PURPOSE
//  Upstream feeder for the byte-striping stage. Takes a packetised byte stream
//  and frames each packet: SOF K-char, payload bytes, EOF K-char, then PAD
//  K-chars up to the next stripe boundary.
//  Packs the framed bytes into NUM_LANES-wide stripes with per-byte K flags.
//  Each stripe feeds the striper and the per-lane 8b/10b encoders.
// PARAMETERS
//  NUM_LANES  4      bytes per stripe / lane count (>=2)
//  SOF_BYTE   8'hFB  start-of-frame symbol (K27.7), K flag=1
//  EOF_BYTE   8'hFD  end-of-frame symbol (K29.7), K flag=1
//  PAD_BYTE   8'hF7  pad symbol (K23.7), K flag=1
//  IDLE_BYTE  8'hBC  idle symbol (K28.5), used only with IDLE_FILL_EN
// PORTS
//  clk      in   1            single clock, all logic on rising edge
//  rst_n    in   1            synchronous, active-low reset
//  s_data   in   8            payload byte
//  s_valid  in   1            s_data valid
//  s_last   in   1            s_data is final payload byte of packet
//  s_ready  out  1            byte accepted when s_valid&&s_ready
//  m_data   out  8*NUM_LANES  stripe; lane i = m_data[8*i+7:8*i], lane 0 = first byte
//  m_k      out  NUM_LANES    K flag per lane (bit i <-> lane i)
//  m_valid  out  1            stripe valid; held stable until m_ready
//  m_ready  in   1            downstream accepts stripe
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): m_valid=0, m_data=0, m_k=0, s_ready=0,
//    FSM=IDLE, slot index idx=0. Any partial stripe or packet is discarded.
//  - Storage: one assembly register (NUM_LANES bytes + K bits, write index idx)
//    and one output register (m_data/m_k/m_valid).
//  - One assembly write per cycle, when wr_ok=1.
//    wr_ok = !(idx==NUM_LANES-1 && m_valid && !m_ready).
//  - Writing slot NUM_LANES-1 completes the stripe. It moves to the output
//    register on the same edge, so m_valid=1 the next cycle (latency 1). idx wraps to 0.
//  - Output handshake: m_valid drops after m_valid&&m_ready unless a new stripe
//    loads on the same edge. m_data/m_k do not change while m_valid&&!m_ready.
//  - FSM (one symbol written per wr_ok cycle):
//    IDLE: idx is always 0 here. If s_valid: write SOF_BYTE (K=1) to lane 0, s_ready=0 -> DATA.
//    DATA: s_ready=wr_ok. On accept, write s_data (K=0).
//          If s_last -> EOF, else stay in DATA.
//    EOF:  s_ready=0. Write EOF_BYTE (K=1).
//          If this write fills the stripe -> IDLE, else -> PAD.
//    PAD:  s_ready=0. Write PAD_BYTE (K=1) until the stripe completes -> IDLE.
//  - Every packet therefore starts at lane 0. A 1-byte packet is legal. There is no
//    maximum packet length.
//  - Stall: if wr_ok=0, FSM, idx and s_ready hold; no symbol is written.
//  - s_valid dropping mid-packet: no write, no padding, DATA state held.
//    The packet continues when s_valid returns.
//  - Back-to-back packets: SOF of packet N+1 lands in lane 0 of the stripe after
//    packet N's EOF/PAD stripe. The packer adds no extra bubble beyond the SOF cycle.
// CONFIGURATION
//  IDLE_FILL_EN defined:
//   - In IDLE with s_valid=0, load an all-IDLE stripe into the output register:
//     m_data = {NUM_LANES{IDLE_BYTE}}, m_k = all 1s.
//   - This happens only when the output register is empty or accepted that cycle,
//     so the line never gaps.
//   - A packet start takes priority. An idle stripe already in the output register
//     is never modified.
//  IDLE_FILL_EN undefined: m_valid=0 whenever no framed stripe is ready.
// TESTING (NUM_LANES=4, m_ready=1 unless stated)
//  1. Packet 11,22,33 -> stripe0 m_data=32'h332211FB, m_k=4'b0001.
//     Then stripe1 m_data=32'hF7F7F7FD, m_k=4'b1111, FSM IDLE.
//  2. Packet AA,BB -> single stripe m_data=32'hFDBBAAFB, m_k=4'b1001;
//     no PAD stripe.
//  3. 8-byte packet, m_ready=0 for 5 cycles once first stripe is valid ->
//     m_data stable, s_ready=0 when the next stripe is full.
//     All bytes appear in order after release; none lost or duplicated.
//  4. rst_n=0 one cycle after 2 payload bytes accepted -> next cycle m_valid=0,
//     s_ready=0. A fresh packet 55 produces m_data=32'hF7FD55FB, m_k=4'b1101.
//  5. Two 3-byte packets with s_valid held high -> 2nd SOF in lane 0 of stripe2;
//     exactly 4 stripes total.
//  6. IDLE_FILL_EN, s_valid=0 -> m_data=32'hBCBCBCBC, m_k=4'b1111 every cycle.
//     When s_valid rises, the next new stripe starts with SOF in lane 0.

Source files
------------

// File: rtl/stripe_packer.sv
`default_nettype none
// ============================================================================
// stripe_packer : frames packets (SOF, payload, EOF, PAD) into NUM_LANES-byte
//                 stripes with per-lane K flags. Optional macro IDLE_FILL_EN
//                 fills the line with all-IDLE stripes between packets.
// Revision      : 1.0
// ============================================================================
module stripe_packer #(
  parameter int         NUM_LANES = 4,
  parameter logic [7:0] SOF_BYTE  = 8'hFB,
  parameter logic [7:0] EOF_BYTE  = 8'hFD,
  parameter logic [7:0] PAD_BYTE  = 8'hF7
`ifdef IDLE_FILL_EN
  ,
  parameter logic [7:0] IDLE_BYTE = 8'hBC
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [8*NUM_LANES-1:0] m_data,
  output logic [NUM_LANES-1:0]   m_k,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int               c_idx_w    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_EOF  = 2'd2,
    ST_PAD  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [c_idx_w-1:0]       idx_q, idx_d;
  logic [8*NUM_LANES-1:0]   asm_data_q, asm_data_d;
  logic [NUM_LANES-1:0]     asm_k_q, asm_k_d;
  logic [8*NUM_LANES-1:0]   m_data_q, m_data_d;
  logic [NUM_LANES-1:0]     m_k_q, m_k_d;
  logic                     m_valid_q, m_valid_d;

  logic                     w_wr_ok;
  logic                     w_wr_en;
  logic                     w_complete;
  logic [7:0]               w_sym;
  logic                     w_sym_k;
  logic                     w_s_ready;

  // The only write blocker: the last slot would complete a stripe while the
  // output register still holds an unaccepted one.
  assign w_wr_ok = !((idx_q == c_last_idx) && m_valid_q && !m_ready);

  always_comb begin
    state_d   = state_q;
    w_wr_en   = 1'b0;
    w_sym     = 8'h00;
    w_sym_k   = 1'b0;
    w_s_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid && w_wr_ok) begin
          w_wr_en = 1'b1;
          w_sym   = SOF_BYTE;
          w_sym_k = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        w_s_ready = w_wr_ok;
        if (s_valid && w_wr_ok) begin
          w_wr_en = 1'b1;
          w_sym   = s_data;
          w_sym_k = 1'b0;
          if (s_last) state_d = ST_EOF;
        end
      end
      ST_EOF: begin
        if (w_wr_ok) begin
          w_wr_en = 1'b1;
          w_sym   = EOF_BYTE;
          w_sym_k = 1'b1;
          state_d = (idx_q == c_last_idx) ? ST_IDLE : ST_PAD;
        end
      end
      ST_PAD: begin
        if (w_wr_ok) begin
          w_wr_en = 1'b1;
          w_sym   = PAD_BYTE;
          w_sym_k = 1'b1;
          if (idx_q == c_last_idx) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_complete = w_wr_en && (idx_q == c_last_idx);
    asm_data_d = asm_data_q;
    asm_k_d    = asm_k_q;
    idx_d      = idx_q;
    if (w_wr_en) begin
      asm_data_d[8*idx_q +: 8] = w_sym;
      asm_k_d[idx_q]           = w_sym_k;
      idx_d                    = w_complete ? '0 : idx_q + 1'b1;
    end

    m_data_d  = m_data_q;
    m_k_d     = m_k_q;
    m_valid_d = m_valid_q;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    // The completing byte bypasses the assembly register into the output.
    if (w_complete) begin
      m_data_d  = asm_data_d;
      m_k_d     = asm_k_d;
      m_valid_d = 1'b1;
    end
`ifdef IDLE_FILL_EN
    else if ((state_q == ST_IDLE) && !s_valid && (!m_valid_q || m_ready)) begin
      m_data_d  = {NUM_LANES{IDLE_BYTE}};
      m_k_d     = '1;
      m_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      asm_data_q <= '0;
      asm_k_q    <= '0;
      m_data_q   <= '0;
      m_k_q      <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      asm_data_q <= asm_data_d;
      asm_k_q    <= asm_k_d;
      m_data_q   <= m_data_d;
      m_k_q      <= m_k_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign s_ready = w_s_ready;
  assign m_data  = m_data_q;
  assign m_k     = m_k_q;
  assign m_valid = m_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_stripe_packer.sv
`default_nettype none
// ============================================================================
// tb_stripe_packer : directed vector table plus stream sequences with stalls.
// Revision         : 1.0
// ============================================================================
module tb_stripe_packer;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [7:0]  s_data  = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic        m_ready = 1'b1;
  logic        s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_k;
  logic        m_valid;

  int n_vec = 0;
  int n_bad = 0;

  stripe_packer #(.NUM_LANES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_k     (m_k),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_ready;
    logic        chk;
    logic        chk_data;
    logic        exp_mv;
    logic [31:0] exp_data;
    logic [3:0]  exp_k;
    logic        exp_sr;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  tx_d[$];
  logic        tx_l[$];
  logic [31:0] rx_d[$];
  logic [3:0]  rx_k[$];
  logic [31:0] ex_d[$];
  logic [3:0]  ex_k[$];

  task automatic add(input logic rn, input logic sv, input logic [7:0] d,
                     input logic sl, input logic mr, input logic ck,
                     input logic ckd, input logic emv, input logic [31:0] ed,
                     input logic [3:0] ek, input logic esr);
    vec_t v;
    v.rst_n = rn; v.s_valid = sv; v.s_data = d; v.s_last = sl; v.m_ready = mr;
    v.chk = ck; v.chk_data = ckd; v.exp_mv = emv; v.exp_data = ed;
    v.exp_k = ek; v.exp_sr = esr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic ok, input string detail);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives queued bytes (s_valid held high while any remain) and collects
  // every accepted stripe. Optionally stalls m_ready once a stripe is valid.
  task automatic run_stream(input int stall_len, input int cycles);
    int          ptr = 0;
    int          stall_left = -1;
    int          stall_no = 0;
    logic [31:0] held = '0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      s_valid = (ptr < tx_d.size());
      s_data  = s_valid ? tx_d[ptr] : 8'h00;
      s_last  = s_valid ? tx_l[ptr] : 1'b0;
      if (stall_left < 0 && stall_len > 0 && m_valid) begin
        stall_left = stall_len;
        held = m_data;
      end
      m_ready = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        stall_no++;
        check($sformatf("stall_hold%0d", stall_no), m_valid && (m_data == held),
              $sformatf("got mv=%0b data=%h, want mv=1 data=%h", m_valid, m_data, held));
        if (stall_left == 1)
          check("stall_s_ready", s_valid && !s_ready,
                $sformatf("got s_valid=%0b s_ready=%0b, want s_valid=1 s_ready=0", s_valid, s_ready));
        stall_left--;
      end
      if (m_valid && m_ready) begin
        rx_d.push_back(m_data);
        rx_k.push_back(m_k);
      end
      if (s_valid && s_ready) ptr++;
    end
    check("tx_drained", ptr == tx_d.size(),
          $sformatf("got %0d bytes accepted, want %0d", ptr, tx_d.size()));
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
  endtask

  task automatic compare_rx(input string name);
    check({name, "_count"}, rx_d.size() == ex_d.size(),
          $sformatf("got %0d stripes, want %0d", rx_d.size(), ex_d.size()));
    for (int i = 0; i < ex_d.size() && i < rx_d.size(); i++)
      check($sformatf("%s_stripe%0d", name, i), (rx_d[i] == ex_d[i]) && (rx_k[i] == ex_k[i]),
            $sformatf("got data=%h k=%b, want data=%h k=%b", rx_d[i], rx_k[i], ex_d[i], ex_k[i]));
    tx_d.delete(); tx_l.delete(); rx_d.delete(); rx_k.delete(); ex_d.delete(); ex_k.delete();
  endtask

  initial begin
`ifndef IDLE_FILL_EN
    // reset
    add(0,0,8'h00,0,1, 0,0, 0,32'h0,4'h0,0);
    add(0,0,8'h00,0,1, 1,1, 0,32'h0,4'h0,0);
    // packet 11,22,33 -> data stripe then EOF/PAD stripe
    add(1,1,8'h11,0,1, 1,1, 0,32'h0,4'h0,0);
    add(1,1,8'h11,0,1, 1,0, 0,32'h0,4'h0,1);
    add(1,1,8'h22,0,1, 1,0, 0,32'h0,4'h0,1);
    add(1,1,8'h33,1,1, 1,0, 0,32'h0,4'h0,1);
    add(1,0,8'h00,0,1, 1,1, 1,32'h332211FB,4'b0001,0);
    add(1,0,8'h00,0,1, 1,0, 0,32'h0,4'h0,0);
    add(1,0,8'h00,0,1, 1,0, 0,32'h0,4'h0,0);
    add(1,0,8'h00,0,1, 1,0, 0,32'h0,4'h0,0);
    add(1,0,8'h00,0,1, 1,1, 1,32'hF7F7F7FD,4'b1111,0);
    add(1,0,8'h00,0,1, 1,0, 0,32'h0,4'h0,0);
    // packet AA,BB -> single stripe, no PAD stripe afterwards
    add(1,1,8'hAA,0,1, 1,0, 0,32'h0,4'h0,0);
    add(1,1,8'hAA,0,1, 1,0, 0,32'h0,4'h0,1);
    add(1,1,8'hBB,1,1, 1,0, 0,32'h0,4'h0,1);
    add(1,0,8'h00,0,1, 1,0, 0,32'h0,4'h0,0);
    add(1,0,8'h00,0,1, 1,1, 1,32'hFDBBAAFB,4'b1001,0);
    add(1,0,8'h00,0,1, 1,0, 0,32'h0,4'h0,0);
    add(1,0,8'h00,0,1, 1,0, 0,32'h0,4'h0,0);
    // reset mid-packet, then 1-byte packet 55
    add(1,1,8'h01,0,1, 1,0, 0,32'h0,4'h0,0);
    add(1,1,8'h01,0,1, 1,0, 0,32'h0,4'h0,1);
    add(1,1,8'h02,0,1, 1,0, 0,32'h0,4'h0,1);
    add(0,1,8'h03,0,1, 0,0, 0,32'h0,4'h0,0);
    add(1,0,8'h00,0,1, 1,1, 0,32'h0,4'h0,0);
    add(1,1,8'h55,1,1, 1,0, 0,32'h0,4'h0,0);
    add(1,1,8'h55,1,1, 1,0, 0,32'h0,4'h0,1);
    add(1,0,8'h00,0,1, 1,0, 0,32'h0,4'h0,0);
    add(1,0,8'h00,0,1, 1,0, 0,32'h0,4'h0,0);
    add(1,0,8'h00,0,1, 1,1, 1,32'hF7FD55FB,4'b1101,0);
    add(1,0,8'h00,0,1, 1,0, 0,32'h0,4'h0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; s_valid = vecs[i].s_valid; s_data = vecs[i].s_data;
      s_last = vecs[i].s_last; m_ready = vecs[i].m_ready;
      #1;
      if (vecs[i].chk)
        check($sformatf("vec%0d", i),
              (m_valid == vecs[i].exp_mv) && (s_ready == vecs[i].exp_sr) &&
              (!vecs[i].chk_data || ((m_data == vecs[i].exp_data) && (m_k == vecs[i].exp_k))),
              $sformatf("got mv=%0b data=%h k=%b sr=%0b, want mv=%0b data=%h k=%b sr=%0b (data checked=%0b)",
                        m_valid, m_data, m_k, s_ready, vecs[i].exp_mv, vecs[i].exp_data,
                        vecs[i].exp_k, vecs[i].exp_sr, vecs[i].chk_data));
    end

    // 8-byte packet with a 5-cycle output stall
    for (int b = 1; b <= 8; b++) begin
      tx_d.push_back(8'(b));
      tx_l.push_back(b == 8);
    end
    ex_d = '{32'h030201FB, 32'h07060504, 32'hF7F7FD08};
    ex_k = '{4'b0001, 4'b0000, 4'b1110};
    run_stream(5, 40);
    compare_rx("stall");

    // two back-to-back 3-byte packets
    tx_d = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
    tx_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ex_d = '{32'h131211FB, 32'hF7F7F7FD, 32'h232221FB, 32'hF7F7F7FD};
    ex_k = '{4'b0001, 4'b1111, 4'b0001, 4'b1111};
    run_stream(0, 40);
    compare_rx("b2b");
`else
    do_reset();
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("idle%0d", c), m_valid && (m_data == 32'hBCBCBCBC) && (m_k == 4'b1111),
            $sformatf("got mv=%0b data=%h k=%b, want mv=1 data=bcbcbcbc k=1111", m_valid, m_data, m_k));
    end
    begin
      int n_frame;
      tx_d = '{8'h77};
      tx_l = '{1'b1};
      run_stream(0, 20);
      n_frame = 0;
      foreach (rx_d[i]) begin
        if (rx_d[i] != 32'hBCBCBCBC || rx_k[i] != 4'b1111) begin
          n_frame++;
          if (n_frame == 1)
            check("idle_pkt", (rx_d[i] == 32'hF7FD77FB) && (rx_k[i] == 4'b1101),
                  $sformatf("got data=%h k=%b, want data=f7fd77fb k=1101", rx_d[i], rx_k[i]));
        end
      end
      check("idle_pkt_count", n_frame == 1,
            $sformatf("got %0d framed stripes, want 1", n_frame));
      check("idle_after", m_valid && (m_data == 32'hBCBCBCBC),
            $sformatf("got mv=%0b data=%h, want mv=1 data=bcbcbcbc", m_valid, m_data));
      tx_d.delete(); tx_l.delete(); rx_d.delete(); rx_k.delete();
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
